// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file writeback port arbiter.
package wb_arb_pkg;

    // Register written by link (JAL/JALR) instructions
    localparam int unsigned LINK_REG_DEF = 31;

    // Source of the registered register-file write
    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_PIPE = 2'b01,
        WB_MDU  = 2'b10
    } wb_src_t;

    // Arbiter state: NORMAL arbitration, or a single forced MDU cycle
    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_hold_slot.sv
// Single-entry buffer for an MDU result waiting for the register-file write port.
// Results aimed at register 0 are accepted and discarded.
module wb_hold_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    output logic              ready,
    output logic              hold_v,
    output logic [ADDR_W-1:0] hold_rd,
    output logic [DATA_W-1:0] hold_data
);

    // Accepting only while empty keeps clear and load mutually exclusive
    assign ready = !hold_v && !Rst;

    // Slot storage: clear on grant, load on accept of a non-zero destination
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_v    <= 1'b0;
            hold_rd   <= '0;
            hold_data <= '0;
        end else if (clr) begin
            hold_v    <= 1'b0;
        end else if (in_valid && ready && (in_rd != '0)) begin
            hold_v    <= 1'b1;
            hold_rd   <= in_rd;
            hold_data <= in_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the MEM/WB stream and
// the buffered MDU result, forcing a one-cycle pipeline stall when the MDU
// result has been denied too long.
// Optional: define WB_STATS_EN to add stall_cnt / mdu_wr_cnt statistics outputs.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned LINK_REG     = LINK_REG_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              pipe_valid,
    input  logic              pipe_regwrite,
    input  logic              pipe_memtoreg,
    input  logic              pipe_link,
    input  logic [DATA_W-1:0] pipe_rdata,
    input  logic [DATA_W-1:0] pipe_alu,
    input  logic [DATA_W-1:0] pipe_pcadd,
    input  logic [ADDR_W-1:0] pipe_rd,
    output logic              pipe_stall,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        wb_src
`ifdef WB_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       mdu_wr_cnt
`endif
);

    localparam int unsigned    CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              grant_pipe, grant_hold;
    wb_src_t           src_d;

    logic              preq;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;

    logic              hold_v;
    logic [ADDR_W-1:0] hold_rd;
    logic [DATA_W-1:0] hold_data;

    // Pipeline write request: link overrides both address and data
    always_comb begin
        pipe_waddr = pipe_link ? ADDR_W'(LINK_REG) : pipe_rd;
        pipe_wdata = pipe_link ? pipe_pcadd : (pipe_memtoreg ? pipe_rdata : pipe_alu);
        preq       = pipe_valid && pipe_regwrite && (pipe_waddr != '0);
    end

    wb_hold_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hold_slot (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (mdu_valid),
        .in_rd     (mdu_rd),
        .in_data   (mdu_data),
        .clr       (grant_hold),
        .ready     (mdu_ready),
        .hold_v    (hold_v),
        .hold_rd   (hold_rd),
        .hold_data (hold_data)
    );

    // State and starvation counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant selection, starvation tracking and next state
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        grant_pipe = 1'b0;
        grant_hold = 1'b0;
        src_d      = WB_NONE;
        case (state_q)
            NORMAL: begin
                if (preq) begin
                    grant_pipe = 1'b1;
                end else if (hold_v) begin
                    grant_hold = 1'b1;
                end
                if (hold_v && !grant_hold) begin
                    if (starve_q != CNT_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    if (starve_d == CNT_MAX) begin
                        state_d = FORCE;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            FORCE: begin
                // Pipe is frozen by the stall and re-presents next cycle
                grant_hold = hold_v;
                starve_d   = '0;
                state_d    = NORMAL;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
        if (grant_pipe) begin
            src_d = WB_PIPE;
        end else if (grant_hold) begin
            src_d = WB_MDU;
        end
    end

    assign pipe_stall = (state_q == FORCE);

    // Registered write port; address and data hold when nothing is granted
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_src   <= WB_NONE;
        end else begin
            rf_we  <= grant_pipe || grant_hold;
            wb_src <= src_d;
            if (grant_pipe) begin
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end else if (grant_hold) begin
                rf_waddr <= hold_rd;
                rf_wdata <= hold_data;
            end
        end
    end

`ifdef WB_STATS_EN
    // Saturating counters of forced-stall cycles and MDU writes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt  <= '0;
            mdu_wr_cnt <= '0;
        end else begin
            if ((state_q == FORCE) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (grant_hold && (mdu_wr_cnt != '1)) begin
                mdu_wr_cnt <= mdu_wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a cycle-level
// behavioural model of the writeback port.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned SL = 4;

    logic          Clk;
    logic          Rst;
    logic          pipe_valid, pipe_regwrite, pipe_memtoreg, pipe_link;
    logic [DW-1:0] pipe_rdata, pipe_alu, pipe_pcadd;
    logic [AW-1:0] pipe_rd;
    logic          pipe_stall;
    logic          mdu_valid, mdu_ready;
    logic [AW-1:0] mdu_rd;
    logic [DW-1:0] mdu_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    wb_src;
`ifdef WB_STATS_EN
    logic [31:0]   stall_cnt, mdu_wr_cnt;
`endif

    wb_port_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .LINK_REG     (31),
        .STARVE_LIMIT (SL)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .pipe_valid    (pipe_valid),
        .pipe_regwrite (pipe_regwrite),
        .pipe_memtoreg (pipe_memtoreg),
        .pipe_link     (pipe_link),
        .pipe_rdata    (pipe_rdata),
        .pipe_alu      (pipe_alu),
        .pipe_pcadd    (pipe_pcadd),
        .pipe_rd       (pipe_rd),
        .pipe_stall    (pipe_stall),
        .mdu_valid     (mdu_valid),
        .mdu_ready     (mdu_ready),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .wb_src        (wb_src)
`ifdef WB_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .mdu_wr_cnt    (mdu_wr_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_hold;
    logic [4:0]  m_hold_rd;
    logic [31:0] m_hold_data;
    int          m_wait;
    bit          m_force;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_src;
    longint      m_stalls, m_mdu_wr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [4:0]  wa;
        logic [31:0] wd;
        bit preq, take_pipe, take_hold;
        if (Rst) begin
            m_hold = 0; m_wait = 0; m_force = 0;
            e_we = 0; e_waddr = '0; e_wdata = '0; e_src = 2'b00;
            m_stalls = 0; m_mdu_wr = 0;
            return;
        end
        wa   = pipe_link ? 5'd31 : pipe_rd;
        wd   = pipe_link ? pipe_pcadd : (pipe_memtoreg ? pipe_rdata : pipe_alu);
        preq = pipe_valid && pipe_regwrite && (wa != 5'd0);
        take_pipe = !m_force && preq;
        take_hold = m_force ? m_hold : (!preq && m_hold);
        if (m_force) m_stalls++;
        if (take_hold) m_mdu_wr++;
        if (m_force) begin
            m_force = 0;
            m_wait  = 0;
        end else if (m_hold && !take_hold) begin
            m_wait++;
            if (m_wait >= SL) m_force = 1;
        end else begin
            m_wait = 0;
        end
        e_we  = take_pipe || take_hold;
        e_src = take_pipe ? 2'b01 : (take_hold ? 2'b10 : 2'b00);
        if (take_pipe) begin
            e_waddr = wa; e_wdata = wd;
        end else if (take_hold) begin
            e_waddr = m_hold_rd; e_wdata = m_hold_data;
        end
        if (take_hold) begin
            m_hold = 0;
        end else if (!m_hold && mdu_valid && (mdu_rd != 5'd0)) begin
            m_hold = 1; m_hold_rd = mdu_rd; m_hold_data = mdu_data;
        end
    endtask

    // One clock: update model, pass the edge, compare every output
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_eq("rf_we",    32'(rf_we),    32'(e_we));
        check_eq("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
        check_eq("rf_wdata", rf_wdata,      e_wdata);
        check_eq("wb_src",   32'(wb_src),   32'(e_src));
        check_eq("stall",    32'(pipe_stall), 32'(m_force));
        check_eq("ready",    32'(mdu_ready),  32'(!m_hold && !Rst));
`ifdef WB_STATS_EN
        check_eq("stall_cnt",  stall_cnt,  32'(m_stalls));
        check_eq("mdu_wr_cnt", mdu_wr_cnt, 32'(m_mdu_wr));
`endif
    endtask

    task automatic pipe_set(input bit v, input bit rw, input bit mem, input bit lnk,
                            input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] rdat, input logic [31:0] pc);
        pipe_valid = v; pipe_regwrite = rw; pipe_memtoreg = mem; pipe_link = lnk;
        pipe_rd = rd; pipe_alu = alu; pipe_rdata = rdat; pipe_pcadd = pc;
    endtask

    task automatic mdu_set(input bit v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v; mdu_rd = rd; mdu_data = d;
    endtask

    // Hold an MDU result behind continuous pipe writes until the forced stall
    task automatic starve_to_force(output int pre_ticks);
        pre_ticks = 0;
        pipe_set(1, 1, 0, 0, 5'd9, 32'h1111, 32'h0, 32'h0);
        mdu_set(1, 5'd5, 32'hBEEF);
        tick();
        mdu_set(0, 5'd0, 32'h0);
        for (int i = 0; i < 10 && !pipe_stall; i++) begin
            pre_ticks++;
            pipe_alu = pipe_alu + 32'd1;
            tick();
        end
        check_eq("force_seen", 32'(pipe_stall), 32'd1);
    endtask

    int pre;

    initial begin
        Rst = 1;
        pipe_set(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        mdu_set(0, 5'd0, 32'h0);

        // Reset and release
        repeat (3) tick();
        Rst = 0;
        tick();
        check_eq("rst_we", 32'(rf_we), 32'd0);
        check_eq("rst_src", 32'(wb_src), 32'd0);
        check_eq("rst_stall", 32'(pipe_stall), 32'd0);
        check_eq("rst_ready", 32'(mdu_ready), 32'd1);

        // ALU write, then link write
        pipe_set(1, 1, 0, 0, 5'd8, 32'h1234, 32'hDEAD, 32'h40);
        tick();
        check_eq("alu_waddr", 32'(rf_waddr), 32'd8);
        check_eq("alu_wdata", rf_wdata, 32'h1234);
        check_eq("alu_src", 32'(wb_src), 32'd1);
        pipe_link = 1;
        tick();
        check_eq("link_waddr", 32'(rf_waddr), 32'd31);
        check_eq("link_wdata", rf_wdata, 32'h40);
        pipe_link = 0; pipe_memtoreg = 1;
        tick();
        check_eq("load_wdata", rf_wdata, 32'hDEAD);

        // Writes to register 0 are suppressed on both sources
        pipe_set(1, 1, 0, 0, 5'd0, 32'h77, 32'h0, 32'h0);
        mdu_set(1, 5'd0, 32'hABCD);
        tick();
        check_eq("r0_pipe_we", 32'(rf_we), 32'd0);
        pipe_set(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        mdu_set(0, 5'd0, 32'h0);
        tick();
        check_eq("r0_mdu_we", 32'(rf_we), 32'd0);
        check_eq("r0_mdu_ready", 32'(mdu_ready), 32'd1);

        // MDU result with idle pipe: ready low exactly one cycle
        mdu_set(1, 5'd5, 32'hBEEF);
        tick();
        check_eq("mdu_acc_ready", 32'(mdu_ready), 32'd0);
        mdu_set(0, 5'd0, 32'h0);
        tick();
        check_eq("mdu_wr_src", 32'(wb_src), 32'd2);
        check_eq("mdu_wr_waddr", 32'(rf_waddr), 32'd5);
        check_eq("mdu_wr_ready", 32'(mdu_ready), 32'd1);

        // Starvation forces one stall cycle, then the MDU write, then pipe resumes
        starve_to_force(pre);
        check_eq("starve_ticks", 32'(pre), 32'(SL));
        tick();
        check_eq("force_src", 32'(wb_src), 32'd2);
        check_eq("force_waddr", 32'(rf_waddr), 32'd5);
        check_eq("force_wdata", rf_wdata, 32'hBEEF);
        check_eq("force_stall_end", 32'(pipe_stall), 32'd0);
        tick();
        check_eq("resume_src", 32'(wb_src), 32'd1);

        // Reset while in FORCE with the slot full discards the result
        starve_to_force(pre);
        Rst = 1;
        tick();
        check_eq("midrst_stall", 32'(pipe_stall), 32'd0);
        Rst = 0;
        pipe_set(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("midrst_no_wr", 32'(rf_we), 32'd0);
        end

        // Random traffic; the pipe is frozen while a stall is expected
        for (int n = 0; n < 3000; n++) begin
            Rst = ($urandom_range(0, 149) == 0);
            if (!m_force) begin
                pipe_set($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                         ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                         $urandom, $urandom, $urandom);
            end
            mdu_set($urandom_range(0, 2) == 0,
                    ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
